// File: rtl/gpio_out_write_arbiter.sv
// Round-robin write arbiter in front of an 8-bit GPIO output PIO (Avalon-MM s1).
// Requesters post masked bit updates. Each update is merged into a shadow copy of
// the PIO register and then issued as a single-cycle zero-wait-state write.
// Because of the shadow copy, the PIO never needs to be read back.
module gpio_out_write_arbiter #(
   parameter int                NUM_REQ     = 4,
   parameter int                DATA_W      = 8,
   parameter int                GAP_CYCLES  = 0,
   parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ*DATA_W-1:0]   req_mask,
   output logic [NUM_REQ-1:0]          ack,
   output logic                        busy,
   output logic [DATA_W-1:0]           shadow_out,
   output logic [1:0]                  avm_address,
   output logic                        avm_chipselect,
   output logic                        avm_write_n,
   output logic [31:0]                 avm_writedata
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [GAP_W-1:0]     gap_cnt_reg, gap_cnt_next;
   logic [PTR_W-1:0]     rr_ptr_reg;
   logic [DATA_W-1:0]    shadow_reg;
   logic [NUM_REQ-1:0]   ack_reg;
   logic                 cs_reg;
   logic                 write_n_reg;
   logic [31:0]          writedata_reg;

   logic [DATA_W-1:0]    data_arr [NUM_REQ];
   logic [DATA_W-1:0]    mask_arr [NUM_REQ];
   logic                 grant_found;
   logic [PTR_W-1:0]     grant_idx;
   logic [DATA_W-1:0]    merged;
   int                   cand_idx;

   // Split the flat request buses into per-requester words.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
         assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
         assign mask_arr[gi] = req_mask[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Round-robin pick: the first asserted request after the last winner, plus its merged value.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
         if (!grant_found && req[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'(cand_idx);
         end
      end
      merged = (shadow_reg & ~mask_arr[grant_idx]) | (data_arr[grant_idx] & mask_arr[grant_idx]);
   end

   // Next-state logic: one write cycle per grant, optionally followed by idle spacing.
   always_comb begin
      state_next   = state_reg;
      gap_cnt_next = gap_cnt_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (grant_found) state_next = ST_WRITE;
         end
         ST_WRITE: begin
            if (GAP_CYCLES > 0) begin
               state_next   = ST_GAP;
               gap_cnt_next = '0;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) state_next = ST_IDLE;
            else                                       gap_cnt_next = gap_cnt_reg + 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State, arbitration pointer, shadow copy and registered Avalon/ack outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_IDLE;
         gap_cnt_reg   <= '0;
         rr_ptr_reg    <= PTR_W'(NUM_REQ - 1);
         shadow_reg    <= RESET_VALUE;
         ack_reg       <= '0;
         cs_reg        <= 1'b0;
         write_n_reg   <= 1'b1;
         writedata_reg <= '0;
      end else begin
         state_reg   <= state_next;
         gap_cnt_reg <= gap_cnt_next;
         ack_reg     <= '0;
         cs_reg      <= 1'b0;
         write_n_reg <= 1'b1;
         if (state_reg == ST_IDLE && grant_found) begin
            rr_ptr_reg    <= grant_idx;
            shadow_reg    <= merged;
            ack_reg       <= NUM_REQ'(1) << grant_idx;
            cs_reg        <= 1'b1;
            write_n_reg   <= 1'b0;
            writedata_reg <= {{(32-DATA_W){1'b0}}, merged};
         end
      end
   end

   assign ack            = ack_reg;
   assign busy           = (state_reg != ST_IDLE);
   assign shadow_out     = shadow_reg;
   assign avm_address    = 2'd0;
   assign avm_chipselect = cs_reg;
   assign avm_write_n    = write_n_reg;
   assign avm_writedata  = writedata_reg;

endmodule

// File: tb/tb_gpio_out_write_arbiter.sv
// Bench for gpio_out_write_arbiter: two instances (no gap / 3-cycle gap) share stimulus.
// Directed vector table, hand-written multi-cycle sequences and a randomized run
// checked against a cycle-countdown reference model.
module tb_gpio_out_write_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [31:0] req_mask = '0;

   logic [3:0]  ack_a, ack_b;
   logic        busy_a, busy_b;
   logic [7:0]  shadow_a, shadow_b;
   logic [1:0]  addr_a, addr_b;
   logic        cs_a, cs_b, wn_a, wn_b;
   logic [31:0] wd_a, wd_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gpio_out_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(0), .RESET_VALUE(8'h00)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_mask(req_mask),
      .ack(ack_a), .busy(busy_a), .shadow_out(shadow_a), .avm_address(addr_a),
      .avm_chipselect(cs_a), .avm_write_n(wn_a), .avm_writedata(wd_a));

   gpio_out_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(3), .RESET_VALUE(8'h00)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_mask(req_mask),
      .ack(ack_b), .busy(busy_b), .shadow_out(shadow_b), .avm_address(addr_b),
      .avm_chipselect(cs_b), .avm_write_n(wn_b), .avm_writedata(wd_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req = '0;
      req_data = '0;
      req_mask = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [31:0] mask;
      logic [3:0]  exp_ack;
      logic [7:0]  exp_wd;
   } vec_t;

   vec_t vecs [6];

   // reference model state, index 0 = no gap, 1 = 3-cycle gap
   int         m_gap    [2] = '{0, 3};
   logic [7:0] m_shadow [2];
   int         m_rr     [2];
   int         m_free   [2];
   logic [31:0] m_wd    [2];

   initial begin
      int order [4];
      int wcyc  [4];
      int ng;
      int cyc;
      logic [3:0]  e_ack [2];
      logic        e_cs  [2];
      logic [3:0]  a_ack;
      logic        a_cs, a_wn, a_busy;
      logic [7:0]  a_sh;
      logic [31:0] a_wd;
      logic [7:0]  d8, m8;
      int          w;

      vecs[0] = '{4'b0001, 32'h0000_00A5, 32'h0000_00FF, 4'b0001, 8'hA5};
      vecs[1] = '{4'b0100, 32'h000F_0000, 32'h000C_0000, 4'b0100, 8'hAD};
      vecs[2] = '{4'b0010, 32'h0000_FF00, 32'h0000_0000, 4'b0010, 8'hAD};
      vecs[3] = '{4'b0011, 32'h0000_FF00, 32'h0000_FFF0, 4'b0001, 8'h0D};
      vecs[4] = '{4'b0011, 32'h0000_FF00, 32'h0000_FFF0, 4'b0010, 8'hFF};
      vecs[5] = '{4'b1000, 32'h3C00_0000, 32'hFF00_0000, 4'b1000, 8'h3C};

      // ---- reset values ----
      do_reset();
      #1;
      chk("reset cs", cs_a, 0);
      chk("reset write_n", wn_a, 1);
      chk("reset addr", addr_a, 0);
      chk("reset wd", wd_a, 0);
      chk("reset ack", ack_a, 0);
      chk("reset busy", busy_a, 0);
      chk("reset shadow", shadow_a, 8'h00);
      chk("reset busy gap", busy_b, 0);

      // ---- reset asserted during WRITE ----
      req = 4'b0001; req_data = 32'h0000_00A5; req_mask = 32'h0000_00FF;
      tick();
      chk("pre-reset write cs", cs_a, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("midreset cs", cs_a, 0);
      chk("midreset write_n", wn_a, 1);
      chk("midreset ack", ack_a, 0);
      chk("midreset busy", busy_a, 0);
      chk("midreset shadow", shadow_a, 0);
      chk("midreset wd", wd_a, 0);
      do_reset();

      // ---- vector table: merge, mask=0 rewrite, rotation wrap ----
      for (int i = 0; i < 6; i++) begin
         req = vecs[i].req; req_data = vecs[i].data; req_mask = vecs[i].mask;
         tick();
         $display("vec %0d: req=%b ack=%b wd=%h shadow=%h", i, req, ack_a, wd_a, shadow_a);
         chk("vec ack", ack_a, vecs[i].exp_ack);
         chk("vec wd", wd_a, {24'h0, vecs[i].exp_wd});
         chk("vec cs", cs_a, 1);
         chk("vec write_n", wn_a, 0);
         chk("vec addr", addr_a, 0);
         chk("vec busy", busy_a, 1);
         chk("vec shadow", shadow_a, vecs[i].exp_wd);
         req = '0;
         tick();
         chk("vec idle cs", cs_a, 0);
         chk("vec idle write_n", wn_a, 1);
         chk("vec idle ack", ack_a, 0);
         chk("vec idle wd hold", wd_a, {24'h0, vecs[i].exp_wd});
      end

      // ---- all four held, dropped after ack: order 0..3, 2 cycles apart ----
      req = 4'b1111; req_data = 32'h1234_5678; req_mask = '0;
      ng = 0;
      for (cyc = 0; cyc < 20 && ng < 4; cyc++) begin
         tick();
         if (ack_a != 0) begin
            for (int b = 0; b < 4; b++) if (ack_a[b]) order[ng] = b;
            wcyc[ng] = cyc;
            ng++;
            req = req & ~ack_a;
         end
      end
      $display("rr4: grants=%0d", ng);
      chk("rr4 grant count", ng, 4);
      for (int i = 0; i < ng; i++) begin
         chk("rr4 order", order[i], i);
         if (i > 0) chk("rr4 spacing", wcyc[i] - wcyc[i-1], 2);
      end
      req = '0;

      // ---- gap instance: writes 5 cycles apart, busy through write+gap ----
      do_reset();
      req = 4'b0011; req_data = 32'h0000_0F0F; req_mask = 32'h0000_FFFF;
      ng = 0;
      for (cyc = 0; cyc < 30 && ng < 2; cyc++) begin
         tick();
         if (ack_b != 0) begin
            wcyc[ng] = cyc;
            order[ng] = (ack_b == 4'b0001) ? 0 : (ack_b == 4'b0010) ? 1 : 9;
            ng++;
            chk("gap busy write", busy_b, 1);
            req = req & ~ack_b;
         end else if (ng == 1) begin
            if (cyc - wcyc[0] <= 3) chk("gap busy", busy_b, 1);
            else                    chk("gap idle busy", busy_b, 0);
            chk("gap cs", cs_b, 0);
            chk("gap write_n", wn_b, 1);
         end
      end
      $display("gap: grants=%0d", ng);
      chk("gap grant count", ng, 2);
      if (ng == 2) begin
         chk("gap spacing", wcyc[1] - wcyc[0], 5);
         chk("gap order0", order[0], 0);
         chk("gap order1", order[1], 1);
      end
      req = '0;

      // ---- randomized run against the reference model, both instances ----
      do_reset();
      for (int k = 0; k < 2; k++) begin
         m_shadow[k] = 8'h00; m_rr[k] = 3; m_free[k] = 0; m_wd[k] = '0;
      end
      for (int n = 0; n < 400; n++) begin
         req      = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         req_data = $urandom;
         req_mask = $urandom;
         for (int k = 0; k < 2; k++) begin
            e_ack[k] = '0;
            e_cs[k]  = 1'b0;
            if (m_free[k] == 0 && req != 0) begin
               w = -1;
               for (int s = 1; s <= 4; s++)
                  if (w < 0 && req[(m_rr[k] + s) % 4]) w = (m_rr[k] + s) % 4;
               d8 = req_data[w*8 +: 8];
               m8 = req_mask[w*8 +: 8];
               for (int b = 0; b < 8; b++)
                  if (m8[b]) m_shadow[k][b] = d8[b];
               m_wd[k]   = {24'h0, m_shadow[k]};
               m_rr[k]   = w;
               m_free[k] = 1 + m_gap[k];
               e_ack[k]  = 4'(1 << w);
               e_cs[k]   = 1'b1;
            end else if (m_free[k] > 0) begin
               m_free[k]--;
            end
         end
         tick();
         for (int k = 0; k < 2; k++) begin
            a_ack  = (k == 0) ? ack_a    : ack_b;
            a_cs   = (k == 0) ? cs_a     : cs_b;
            a_wn   = (k == 0) ? wn_a     : wn_b;
            a_busy = (k == 0) ? busy_a   : busy_b;
            a_sh   = (k == 0) ? shadow_a : shadow_b;
            a_wd   = (k == 0) ? wd_a     : wd_b;
            if (e_cs[k]) $display("rand %0d inst%0d: write ack=%b wd=%h", n, k, a_ack, a_wd);
            chk("rand ack", a_ack, e_ack[k]);
            chk("rand cs", a_cs, e_cs[k]);
            chk("rand write_n", a_wn, !e_cs[k]);
            chk("rand wd", a_wd, m_wd[k]);
            chk("rand shadow", a_sh, m_shadow[k]);
            chk("rand busy", a_busy, m_free[k] > 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
